// File: rtl/serdes_pkg.sv
// Shared SerDes link definitions: word geometry, alignment pattern and receiver states.
package serdes_pkg;

   localparam int          DATA_W_DEF    = 8;
   localparam logic [7:0]  SYNC_WORD_DEF = 8'hA5;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } deser_state_e;

endpackage

// File: rtl/serdes_shift_reg.sv
// LSB-first deserialising shift register: new bit enters at the MSB and moves right,
// so after DATA_W shifts bit 0 holds the first bit received.
module serdes_shift_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              din,
   output logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] q_next
);

   assign q_next = {din, q[DATA_W-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: hunts for the sync pattern, then assembles LSB-first words
// and hands them to the consumer over a valid/ready port with sticky overrun.
//
//   state  | meaning
//   HUNT   | searching the bit stream for SYNC_WORD; no words delivered
//   LOCKED | word boundary known; every DATA_W sampled bits form one data word
module serial_deser
   import serdes_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_data,
   input  logic              ser_valid,
   input  logic              realign,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              locked,
   output logic              overrun
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   deser_state_e      state, state_next;
   logic [1:0]        rst_pipe;
   logic              rst_hold;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] sreg_next;
   logic              last_bit;
   logic              word_done;
   logic              accept;

   // Reset asserts immediately but the core stays cleared for two edges after release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_pipe <= '1;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end

   assign rst_hold = rst_pipe[1];

   serdes_shift_reg #(
      .DATA_W (DATA_W)
   ) u_sreg (
      .clk    (clk),
      .rst    (rst),
      .en     (ser_valid),
      .clr    (realign | rst_hold),
      .din    (ser_data),
      .q      (sreg),
      .q_next (sreg_next)
   );

   assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
   assign word_done = (state == LOCKED) && ser_valid && last_bit && !realign;
   assign accept    = data_valid && data_ready;
   assign locked    = (state == LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
      end else if (rst_hold) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         HUNT: begin
            if (!realign && ser_valid && (sreg_next == SYNC_WORD)) begin
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (realign) begin
               state_next = HUNT;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (rst_hold) begin
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (realign) begin
            bit_cnt <= '0;
            overrun <= 1'b0;
         end else if (ser_valid && (state == LOCKED)) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         end

         // A completing word may replace the one being accepted on the same edge
         if (word_done && (!data_valid || data_ready)) begin
            data_out   <= sreg_next;
            data_valid <= 1'b1;
         end else if (word_done) begin
            overrun    <= 1'b1;
         end else if (accept) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: directed scenarios plus randomized traffic, all checked
// against a bit-level behavioural model of the receiver.
module tb_serial_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_data = 1'b0;
   logic       ser_valid = 1'b0;
   logic       realign = 1'b0;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;
   logic       overrun;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   serial_deser #(
      .DATA_W    (8),
      .SYNC_WORD (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_data   (ser_data),
      .ser_valid  (ser_valid),
      .realign    (realign),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .locked     (locked),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Behavioural model: bit lists and counters rather than a shift register
   bit         hunt_q[$];
   logic [7:0] m_acc;
   int         m_n;
   logic       m_lock;
   logic [7:0] m_dout;
   logic       m_dv;
   logic       m_ovr;
   logic [7:0] acc_q[$];
   int         acc_cyc[$];
   logic [7:0] win;
   logic       take;
   logic       done;
   logic [7:0] word;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hunt_q.delete();
         m_acc = '0; m_n = 0; m_lock = 0; m_dout = '0; m_dv = 0; m_ovr = 0;
      end else begin
         cyc++;
         take = m_dv && data_ready;
         done = 0;
         word = '0;
         if (take) begin
            acc_q.push_back(m_dout);
            acc_cyc.push_back(cyc);
         end
         if (realign) begin
            m_lock = 0; hunt_q.delete(); m_n = 0; m_acc = '0; m_ovr = 0;
         end else if (ser_valid) begin
            if (!m_lock) begin
               hunt_q.push_back(ser_data);
               if (hunt_q.size() > 8) void'(hunt_q.pop_front());
               win = '0;
               for (int k = 0; k < 8; k++)
                  if (hunt_q.size() > k) win[7-k] = hunt_q[hunt_q.size()-1-k];
               if (win == 8'hA5) begin
                  m_lock = 1; m_n = 0; m_acc = '0; hunt_q.delete();
               end
            end else begin
               m_acc[m_n] = ser_data;
               m_n++;
               if (m_n == 8) begin
                  done = 1; word = m_acc; m_acc = '0; m_n = 0;
               end
            end
         end
         if (done) begin
            if (!m_dv || take) begin
               m_dout = word; m_dv = 1;
            end else begin
               m_ovr = 1;
            end
         end else if (take) begin
            m_dv = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         checks++;
         if ({data_out, data_valid, locked, overrun} !== {m_dout, m_dv, m_lock, m_ovr}) begin
            failures++;
            $display("FAIL model_cmp cyc=%0d dut(out=%0h v=%0b lk=%0b ov=%0b) model(out=%0h v=%0b lk=%0b ov=%0b)",
                     cyc, data_out, data_valid, locked, overrun, m_dout, m_dv, m_lock, m_ovr);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      ser_data = b; ser_valid = 1'b1; realign = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ser_valid = 1'b0; realign = 1'b0;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         send_bit(w[i]);
         if (gaps) idle(1);
      end
   endtask

   task automatic pulse_realign();
      @(negedge clk);
      ser_valid = 1'b0; realign = 1'b1;
      @(negedge clk);
      realign = 1'b0;
   endtask

   initial begin
      logic [7:0] a5;
      logic [7:0] w;
      a5 = 8'hA5;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(4);
      check("reset_locked", {31'd0, locked}, 32'd0);
      check("reset_valid", {31'd0, data_valid}, 32'd0);

      // Lock then first word
      data_ready = 1'b0;
      send_word(8'hA5, 0);
      idle(1);
      check("lock_after_sync", {31'd0, locked}, 32'd1);
      check("no_valid_on_sync", {31'd0, data_valid}, 32'd0);
      send_word(8'h3C, 0);
      idle(1);
      check("first_word_valid", {31'd0, data_valid}, 32'd1);
      check("first_word_data", {24'd0, data_out}, 32'h3C);

      // False-sync hunt
      data_ready = 1'b1;
      pulse_realign();
      idle(2);
      check("realign_unlock", {31'd0, locked}, 32'd0);
      send_word(8'h00, 0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(a5[i]);
      idle(1);
      check("no_false_lock", {31'd0, locked}, 32'd0);
      check("no_valid_hunting", {31'd0, data_valid}, 32'd0);
      send_bit(a5[7]);
      idle(1);
      check("true_lock", {31'd0, locked}, 32'd1);

      // Back-to-back with ready held high
      pulse_realign();
      idle(2);
      acc_q.delete(); acc_cyc.delete();
      send_word(8'hA5, 0);
      send_word(8'h11, 0);
      send_word(8'h22, 0);
      send_word(8'h33, 0);
      idle(3);
      check("b2b_count", acc_q.size(), 32'd3);
      if (acc_q.size() == 3) begin
         check("b2b_w0", {24'd0, acc_q[0]}, 32'h11);
         check("b2b_w1", {24'd0, acc_q[1]}, 32'h22);
         check("b2b_w2", {24'd0, acc_q[2]}, 32'h33);
         check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd8);
         check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd8);
      end
      check("b2b_no_overrun", {31'd0, overrun}, 32'd0);
      check("b2b_drained", {31'd0, data_valid}, 32'd0);

      // Overrun
      data_ready = 1'b0;
      send_word(8'h55, 0);
      send_word(8'hAA, 0);
      idle(1);
      check("ovr_data_kept", {24'd0, data_out}, 32'h55);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      @(negedge clk);
      data_ready = 1'b1;
      idle(1);
      check("ovr_drain_valid", {31'd0, data_valid}, 32'd0);
      check("ovr_drain_word", {24'd0, acc_q[acc_q.size()-1]}, 32'h55);

      // Gapped word, then realign mid-word
      data_ready = 1'b0;
      send_word(8'h81, 1);
      idle(1);
      check("gap_valid", {31'd0, data_valid}, 32'd1);
      check("gap_data", {24'd0, data_out}, 32'h81);
      data_ready = 1'b1;
      idle(2);
      data_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      @(negedge clk);
      ser_data = 1'b1; ser_valid = 1'b1; realign = 1'b1;
      idle(1);
      check("ra_unlocked", {31'd0, locked}, 32'd0);
      check("ra_ovr_clear", {31'd0, overrun}, 32'd0);
      check("ra_no_partial", {31'd0, data_valid}, 32'd0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      idle(1);
      check("ra_still_no_word", {31'd0, data_valid}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         w = ($urandom_range(3) == 0) ? 8'hA5 : 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ser_data   = w[i];
            ser_valid  = ($urandom_range(4) != 0);
            realign    = ($urandom_range(149) == 0);
            data_ready = ($urandom_range(2) != 0);
         end
      end
      idle(2);

      // Asynchronous reset in the middle of a word
      data_ready = 1'b0;
      pulse_realign();
      idle(1);
      send_word(8'hA5, 0);
      send_word(8'h5A, 0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      idle(1);
      check("pre_rst_valid", {31'd0, data_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out", {24'd0, data_out}, 32'd0);
      check("async_rst_valid", {31'd0, data_valid}, 32'd0);
      check("async_rst_locked", {31'd0, locked}, 32'd0);
      check("async_rst_ovr", {31'd0, overrun}, 32'd0);
      @(negedge clk);
      ser_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(4);
      check("post_rst_hunt", {31'd0, locked}, 32'd0);
      send_word(8'hA5, 0);
      send_word(8'h77, 0);
      idle(1);
      check("post_rst_word", {24'd0, data_out}, 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
